data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Responder end of the core's data SRAM interface: accepts the `data_sram_en/we/addr/wdata` requests issued by the EX stage and returns `data_sram_rdata` one cycle later for the MEM stage. It decodes each access into either a byte-writable on-chip RAM or a small confreg window, which holds a LED register, a synchronised switch input, a free-running timer with compare interrupt and a scratch register. It sits outside the CPU top, in the SoC/testbench layer, and serves as the standalone data-side memory for pipeline bring-up.

## Interface
- `RAM_AW`, default 14: RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- `CONF_BASE`, default 32'hbfaf_0000: confreg window base; matched on `addr[31:16]`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_sram_en`  in  1  access request this cycle.
- `data_sram_we`  in  4  byte write enables; 4'b0000 with `en` means read.
- `data_sram_addr`  in  32  byte address; bits [1:0] are ignored for word selection.
- `data_sram_wdata`  in  32  write data, byte lanes aligned to `we`.
- `data_sram_rdata`  out  32  registered read data.
- `switch_in`  in  8  asynchronous board switches.
- `led_out`  out  16  LED register value.
- `timer_int`  out  1  sticky timer-compare interrupt.

## Operation
- **Region select.** Conf hit when `addr[31:16]==CONF_BASE[31:16]`. Otherwise the access goes to RAM at word index `addr[RAM_AW+1:2]`; higher address bits alias.
- **Conf offsets (`addr[15:0]`):**
  - 0xF000 LED: R/W, low 16 bits only.
  - 0xF020 SWITCH: read-only; reads {24'b0, sync}.
  - 0xE000 TIMER: R/W.
  - 0xE004 TCMP: R/W.
  - 0xE008 INTCLR: write-only; any write clears `timer_int`; reads 0.
  - 0xF010 SCRATCH: R/W.
  - All other offsets read 0 and ignore writes.
- **Byte enables.** Writes honour `we` per byte on every writable target; unwritten bytes keep their value.
- **Read path.** A read (`en && we==0`) loads `rdata` at the edge. `rdata` holds its value when `en==0` or on a write.
- **Switch synchroniser.** `switch_in` passes through two flops; SWITCH reads the second flop.
- **Timer.** Increments by 1 every cycle and wraps 0xFFFF_FFFF→0. A write to TIMER loads the merged value, then incrementing resumes the following cycle.
- **Interrupt.** `timer_int` sets on the cycle after TIMER equals TCMP, and stays set until an INTCLR write. If set and clear occur in the same cycle, set wins.

## Timing
- Read latency is exactly 1: request at cycle N → `rdata` valid at N+1. There is no stall or handshake; the responder accepts every cycle.
- Write latency is 0: a read of the same address at N+1 returns the data written at N, for both RAM and registers.
- Reset values:
  - `rdata` = 0, `led_out` = 0, TIMER = 0, TCMP = 0xFFFF_FFFF, SCRATCH = 0, `timer_int` = 0, synchroniser flops = 0.
  - RAM contents are not reset.
- `reset` asserted mid-access discards that access; `rdata` = 0 in the next cycle.
- A TIMER write in the same cycle as the increment takes the written value; the increment for that cycle is dropped.

## Structure
- Shared package holds `CONF_BASE`, the offset constants (`OFF_LED`, `OFF_SWITCH`, `OFF_TIMER`, `OFF_TCMP`, `OFF_INTCLR`, `OFF_SCRATCH`) and a byte-merge function: given old value, `wdata` and `we`, it returns the new value.
- One sub-module, `sp_ram_bytewe`: a single-port RAM of 2^RAM_AW×32 with 4 byte write enables and a registered read.
- The top level of this block holds the decode, the conf registers and the rdata mux. The mux selects the RAM or register source using a registered region/offset from cycle N.

## Test plan
- **RAM write/read:** write 0x12345678 to 0x1c000100 with we=4'hF, then read the same address next cycle → `rdata`=0x12345678 one cycle after the read request.
- **Byte merge:** write SCRATCH 0xAABBCCDD (we=F), then write 0x00001100 with we=4'b0010, then read → 0xAABB11DD.
- **LED/switch:** write LED 0xFFFF_A5A5 → `led_out`=0xA5A5. Set `switch_in`=0x3C → a SWITCH read issued ≥2 cycles later returns 0x0000003C.
- **Timer wrap and interrupt:** write TCMP=0x0000_0002, then TIMER=0xFFFF_FFFE; expect a wrap to 0, then `timer_int`=1 the cycle after TIMER reads 2. Clear and re-set in the same cycle → `timer_int` remains 1. A lone INTCLR write → 0.
- **Reset mid-operation:** assert `reset` while a read is issued → `rdata`=0, `led_out`=0, `timer_int`=0 next cycle. Previously written RAM data survives and reads back unchanged.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data SRAM responder: confreg window
// base, register offsets and the byte-enable merge used by all writable targets.
package data_sram_responder_pkg;

  localparam logic [31:0] CONF_BASE = 32'hbfaf_0000;

  localparam logic [15:0] OFF_LED     = 16'hf000;
  localparam logic [15:0] OFF_SWITCH  = 16'hf020;
  localparam logic [15:0] OFF_TIMER   = 16'he000;
  localparam logic [15:0] OFF_TCMP    = 16'he004;
  localparam logic [15:0] OFF_INTCLR  = 16'he008;
  localparam logic [15:0] OFF_SCRATCH = 16'hf010;

  // Replace only the byte lanes flagged in we; other lanes keep old_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  we);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sp_ram_bytewe.sv
// Single-port 2^AW x 32 RAM with per-byte write enables and a registered
// read port that only updates on a read (en with we == 0).
module sp_ram_bytewe #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // NOTE: the array has no reset branch so it maps onto block RAM; contents
  // are undefined until written.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: decodes each access into on-chip RAM or the
// confreg window (LED, switches, timer/compare interrupt, scratch).
module data_sram_responder #(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] CONF_BASE = data_sram_responder_pkg::CONF_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic        timer_int
);

  import data_sram_responder_pkg::*;

  logic        conf_hit;
  logic [15:0] off;
  logic        rd_req;
  logic        conf_wr;
  logic        ram_en;
  logic [31:0] ram_rdata;
  logic [31:0] conf_rdata;
  logic [31:0] wr_merged;

  logic [15:0] led_q;
  logic [7:0]  sw_meta_q;
  logic [7:0]  sw_sync_q;
  logic [31:0] timer_q;
  logic [31:0] tcmp_q;
  logic [31:0] scratch_q;
  logic        int_q;
  logic [31:0] conf_rd_q;
  logic        src_ram_q;

  assign conf_hit = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign off      = data_sram_addr[15:0];
  assign rd_req   = data_sram_en && (data_sram_we == 4'b0000);
  assign conf_wr  = data_sram_en && (data_sram_we != 4'b0000) && conf_hit;
  // A RAM access arriving during reset is discarded, including writes.
  assign ram_en   = data_sram_en && !conf_hit && !reset;

  sp_ram_bytewe #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (data_sram_we),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: every always_comb output gets a default before the case so no
  // latch is inferred for offsets that are not listed.
  always_comb begin
    conf_rdata = 32'h0;
    case (off)
      OFF_LED:     conf_rdata = {16'h0, led_q};
      OFF_SWITCH:  conf_rdata = {24'h0, sw_sync_q};
      OFF_TIMER:   conf_rdata = timer_q;
      OFF_TCMP:    conf_rdata = tcmp_q;
      OFF_SCRATCH: conf_rdata = scratch_q;
      default:     conf_rdata = 32'h0;
    endcase
  end

  // The current register value doubles as the old value for the byte merge.
  assign wr_merged = byte_merge(conf_rdata, data_sram_wdata, data_sram_we);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block take priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= 16'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
      timer_q   <= 32'h0;
      tcmp_q    <= 32'hffff_ffff;
      scratch_q <= 32'h0;
      int_q     <= 1'b0;
      conf_rd_q <= 32'h0;
      src_ram_q <= 1'b0;
    end else begin
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
      timer_q   <= timer_q + 32'd1;

      if (conf_wr && off == OFF_INTCLR) int_q <= 1'b0;
      if (timer_q == tcmp_q)            int_q <= 1'b1;

      if (conf_wr) begin
        case (off)
          OFF_LED:     led_q     <= wr_merged[15:0];
          OFF_TIMER:   timer_q   <= wr_merged;
          OFF_TCMP:    tcmp_q    <= wr_merged;
          OFF_SCRATCH: scratch_q <= wr_merged;
          default:     ;
        endcase
      end

      if (rd_req) begin
        src_ram_q <= !conf_hit;
        if (conf_hit) conf_rd_q <= conf_rdata;
      end
    end
  end

  // Both sources hold their last read value, so rdata is stable between reads.
  assign data_sram_rdata = src_ram_q ? ram_rdata : conf_rd_q;
  assign led_out         = led_q;
  assign timer_int       = int_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
module tb_data_sram_responder;

  localparam logic [31:0] A_LED     = 32'hbfaf_f000;
  localparam logic [31:0] A_SWITCH  = 32'hbfaf_f020;
  localparam logic [31:0] A_TIMER   = 32'hbfaf_e000;
  localparam logic [31:0] A_TCMP    = 32'hbfaf_e004;
  localparam logic [31:0] A_INTCLR  = 32'hbfaf_e008;
  localparam logic [31:0] A_SCRATCH = 32'hbfaf_f010;
  localparam logic [31:0] A_UNMAP   = 32'hbfaf_1234;
  localparam logic [31:0] A_RAM0    = 32'h1c00_0100;
  localparam logic [31:0] A_RAM0_AL = 32'h1c01_0100;
  localparam logic [31:0] A_RAM1    = 32'h1c00_0200;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic        timer_int;

  int pass_cnt  = 0;
  int total_cnt = 0;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out),
    .timer_int       (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] we);
    data_sram_en    = 1'b1;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    data_sram_en   = 1'b1;
    data_sram_we   = 4'h0;
    data_sram_addr = addr;
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    d = data_sram_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) idle();
    total_cnt++;
    if (data_sram_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", data_sram_rdata);
    else pass_cnt++;
    total_cnt++;
    if (led_out !== 16'h0) $display("FAIL rst_led got=%h exp=0", led_out);
    else pass_cnt++;
    total_cnt++;
    if (timer_int !== 1'b0) $display("FAIL rst_int got=%b exp=0", timer_int);
    else pass_cnt++;
    reset = 1'b0;
    bus_read(A_TIMER, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL rst_timer got=%h exp=0", d);
    else pass_cnt++;
    bus_read(A_TCMP, d);
    total_cnt++;
    if (d !== 32'hffff_ffff) $display("FAIL rst_tcmp got=%h exp=ffffffff", d);
    else pass_cnt++;
    bus_read(A_SCRATCH, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL rst_scratch got=%h exp=0", d);
    else pass_cnt++;
  endtask

  task automatic test_ram();
    logic [31:0] d;
    bus_write(A_RAM0, 32'h1234_5678, 4'hf);
    bus_read(A_RAM0, d);
    total_cnt++;
    if (d !== 32'h1234_5678) $display("FAIL ram_rw got=%h exp=12345678", d);
    else pass_cnt++;
    idle();
    total_cnt++;
    if (data_sram_rdata !== 32'h1234_5678) $display("FAIL rdata_hold_idle got=%h exp=12345678", data_sram_rdata);
    else pass_cnt++;
    bus_write(A_RAM1, 32'hcafe_f00d, 4'hf);
    total_cnt++;
    if (data_sram_rdata !== 32'h1234_5678) $display("FAIL rdata_hold_wr got=%h exp=12345678", data_sram_rdata);
    else pass_cnt++;
    bus_write(A_RAM0, 32'hab00_0000, 4'b1000);
    bus_read(A_RAM0_AL, d);
    total_cnt++;
    if (d !== 32'hab34_5678) $display("FAIL ram_byte_alias got=%h exp=ab345678", d);
    else pass_cnt++;
    bus_read(A_RAM1, d);
    total_cnt++;
    if (d !== 32'hcafe_f00d) $display("FAIL ram_word1 got=%h exp=cafef00d", d);
    else pass_cnt++;
  endtask

  task automatic test_byte_merge();
    logic [31:0] d;
    bus_write(A_SCRATCH, 32'haabb_ccdd, 4'hf);
    bus_write(A_SCRATCH, 32'h0000_1100, 4'b0010);
    bus_read(A_SCRATCH, d);
    total_cnt++;
    if (d !== 32'haabb_11dd) $display("FAIL scratch_merge got=%h exp=aabb11dd", d);
    else pass_cnt++;
    bus_write(A_UNMAP, 32'hffff_ffff, 4'hf);
    bus_read(A_UNMAP, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL unmapped got=%h exp=0", d);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_read(A_RAM0, d);
    total_cnt++;
    if (d !== 32'hab34_5678) $display("FAIL b2b_ram got=%h exp=ab345678", d);
    else pass_cnt++;
    bus_read(A_SCRATCH, d);
    total_cnt++;
    if (d !== 32'haabb_11dd) $display("FAIL b2b_conf got=%h exp=aabb11dd", d);
    else pass_cnt++;
    bus_read(A_RAM1, d);
    total_cnt++;
    if (d !== 32'hcafe_f00d) $display("FAIL b2b_ram1 got=%h exp=cafef00d", d);
    else pass_cnt++;
  endtask

  task automatic test_led_switch();
    logic [31:0] d;
    bus_write(A_LED, 32'hffff_a5a5, 4'hf);
    total_cnt++;
    if (led_out !== 16'ha5a5) $display("FAIL led_out got=%h exp=a5a5", led_out);
    else pass_cnt++;
    bus_read(A_LED, d);
    total_cnt++;
    if (d !== 32'h0000_a5a5) $display("FAIL led_read got=%h exp=0000a5a5", d);
    else pass_cnt++;
    bus_write(A_LED, 32'h0000_3c00, 4'b0010);
    total_cnt++;
    if (led_out !== 16'h3ca5) $display("FAIL led_byte got=%h exp=3ca5", led_out);
    else pass_cnt++;
    switch_in = 8'h3c;
    repeat (2) idle();
    bus_read(A_SWITCH, d);
    total_cnt++;
    if (d !== 32'h0000_003c) $display("FAIL switch got=%h exp=0000003c", d);
    else pass_cnt++;
  endtask

  task automatic test_timer();
    logic [31:0] d;
    logic [31:0] exp_t [5];
    exp_t = '{32'hffff_fffe, 32'hffff_ffff, 32'h0, 32'h1, 32'h2};
    total_cnt++;
    if (timer_int !== 1'b0) $display("FAIL int_idle got=%b exp=0", timer_int);
    else pass_cnt++;
    bus_write(A_TCMP, 32'h0000_0002, 4'hf);
    bus_write(A_TIMER, 32'hffff_fffe, 4'hf);
    for (int i = 0; i < 5; i++) begin
      bus_read(A_TIMER, d);
      total_cnt++;
      if (d !== exp_t[i]) $display("FAIL timer_seq%0d got=%h exp=%h", i, d, exp_t[i]);
      else pass_cnt++;
      if (i == 3) begin
        total_cnt++;
        if (timer_int !== 1'b0) $display("FAIL int_early got=%b exp=0", timer_int);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (timer_int !== 1'b1) $display("FAIL int_set got=%b exp=1", timer_int);
    else pass_cnt++;
    bus_write(A_INTCLR, 32'h0, 4'hf);
    total_cnt++;
    if (timer_int !== 1'b0) $display("FAIL int_clr got=%b exp=0", timer_int);
    else pass_cnt++;
    bus_read(A_INTCLR, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL intclr_read got=%h exp=0", d);
    else pass_cnt++;
    bus_write(A_TCMP, 32'h0000_0102, 4'hf);
    bus_write(A_TIMER, 32'h0000_0100, 4'hf);
    repeat (2) idle();
    total_cnt++;
    if (timer_int !== 1'b0) $display("FAIL int_pre_race got=%b exp=0", timer_int);
    else pass_cnt++;
    bus_write(A_INTCLR, 32'h0, 4'hf);
    total_cnt++;
    if (timer_int !== 1'b1) $display("FAIL int_set_wins got=%b exp=1", timer_int);
    else pass_cnt++;
    bus_write(A_INTCLR, 32'h0, 4'hf);
    total_cnt++;
    if (timer_int !== 1'b0) $display("FAIL int_clr2 got=%b exp=0", timer_int);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d;
    bus_write(A_TCMP, 32'h0000_0050, 4'hf);
    bus_write(A_TIMER, 32'h0000_0050, 4'hf);
    idle();
    total_cnt++;
    if (timer_int !== 1'b1) $display("FAIL int_pre_reset got=%b exp=1", timer_int);
    else pass_cnt++;
    data_sram_en   = 1'b1;
    data_sram_we   = 4'h0;
    data_sram_addr = A_RAM1;
    reset          = 1'b1;
    idle();
    data_sram_en = 1'b0;
    reset        = 1'b0;
    total_cnt++;
    if (data_sram_rdata !== 32'h0) $display("FAIL mid_rst_rdata got=%h exp=0", data_sram_rdata);
    else pass_cnt++;
    total_cnt++;
    if (led_out !== 16'h0) $display("FAIL mid_rst_led got=%h exp=0", led_out);
    else pass_cnt++;
    total_cnt++;
    if (timer_int !== 1'b0) $display("FAIL mid_rst_int got=%b exp=0", timer_int);
    else pass_cnt++;
    bus_read(A_TIMER, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL mid_rst_timer got=%h exp=0", d);
    else pass_cnt++;
    bus_read(A_RAM1, d);
    total_cnt++;
    if (d !== 32'hcafe_f00d) $display("FAIL ram_survive1 got=%h exp=cafef00d", d);
    else pass_cnt++;
    bus_read(A_RAM0, d);
    total_cnt++;
    if (d !== 32'hab34_5678) $display("FAIL ram_survive0 got=%h exp=ab345678", d);
    else pass_cnt++;
  endtask

  initial begin
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    switch_in       = 8'h0;
    test_reset();
    test_ram();
    test_byte_merge();
    test_back_to_back();
    test_led_switch();
    test_timer();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
